// File: rtl/pkt_receiver.sv
// Receive path for the top-k kernel: turns TCP/IP stack notifications into read
// requests and forwards returned payload beats tagged with session and length.
module pkt_receiver #(
  parameter int DATA_W = 512,
  parameter int SID_W  = 16,
  parameter int LEN_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst,

  input  logic [87:0]                   s_axis_notifications_TDATA,
  input  logic                          s_axis_notifications_TVALID,
  output logic                          s_axis_notifications_TREADY,

  output logic [LEN_W+SID_W-1:0]        m_axis_read_package_TDATA,
  output logic                          m_axis_read_package_TVALID,
  input  logic                          m_axis_read_package_TREADY,

  input  logic [SID_W-1:0]              s_axis_rx_metadata_TDATA,
  input  logic                          s_axis_rx_metadata_TVALID,
  output logic                          s_axis_rx_metadata_TREADY,

  input  logic [DATA_W-1:0]             s_axis_rx_data_TDATA,
  input  logic [DATA_W/8-1:0]           s_axis_rx_data_TKEEP,
  input  logic                          s_axis_rx_data_TLAST,
  input  logic                          s_axis_rx_data_TVALID,
  output logic                          s_axis_rx_data_TREADY,

  output logic [LEN_W+SID_W+DATA_W:0]   pkt_tx_TDATA,
  output logic                          pkt_tx_TVALID,
  input  logic                          pkt_tx_TREADY,

  output logic [31:0]                   stat_pkt_count,
  output logic [31:0]                   stat_drop_count,
  output logic                          stat_sid_mismatch
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_META,
    ST_DATA
  } state_e;

  state_e             state_q, state_d;
  logic [SID_W-1:0]   req_sid_q, req_sid_d;
  logic [LEN_W-1:0]   req_len_q, req_len_d;
  logic [SID_W-1:0]   out_sid_q, out_sid_d;
  logic [31:0]        pkt_cnt_q, pkt_cnt_d;
  logic [31:0]        drop_cnt_q, drop_cnt_d;
  logic               mismatch_q, mismatch_d;

  logic               notif_rdy, req_vld, meta_rdy, tx_vld, rx_rdy;

  logic [SID_W-1:0]   notif_sid;
  logic [LEN_W-1:0]   notif_len;
  logic               notif_closed;

  assign notif_sid    = s_axis_notifications_TDATA[SID_W-1:0];
  assign notif_len    = s_axis_notifications_TDATA[16 +: LEN_W];
  assign notif_closed = s_axis_notifications_TDATA[80];

  // IP, port and TKEEP carry nothing this block acts on.
  logic unused_bits;
  assign unused_bits = ^{s_axis_notifications_TDATA[79:32],
                         s_axis_notifications_TDATA[87:81],
                         s_axis_rx_data_TKEEP};

  always_comb begin
    state_d    = state_q;
    req_sid_d  = req_sid_q;
    req_len_d  = req_len_q;
    out_sid_d  = out_sid_q;
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    mismatch_d = mismatch_q;
    notif_rdy  = 1'b0;
    req_vld    = 1'b0;
    meta_rdy   = 1'b0;
    tx_vld     = 1'b0;
    rx_rdy     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        notif_rdy = 1'b1;
        if (s_axis_notifications_TVALID) begin
          if (notif_closed || (notif_len == '0)) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
          end else begin
            req_sid_d = notif_sid;
            req_len_d = notif_len;
            state_d   = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        req_vld = 1'b1;
        if (m_axis_read_package_TREADY) state_d = ST_META;
      end
      ST_META: begin
        meta_rdy = 1'b1;
        if (s_axis_rx_metadata_TVALID) begin
          out_sid_d = s_axis_rx_metadata_TDATA;
          if (s_axis_rx_metadata_TDATA != req_sid_q) mismatch_d = 1'b1;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_vld = s_axis_rx_data_TVALID;
        rx_rdy = pkt_tx_TREADY;
        if (s_axis_rx_data_TVALID && pkt_tx_TREADY && s_axis_rx_data_TLAST) begin
          pkt_cnt_d = pkt_cnt_q + 32'd1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_sid_q  <= '0;
      req_len_q  <= '0;
      out_sid_q  <= '0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_sid_q  <= req_sid_d;
      req_len_q  <= req_len_d;
      out_sid_q  <= out_sid_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      mismatch_q <= mismatch_d;
    end
  end

  // Handshake outputs are masked by rst so nothing is offered or taken while held in reset.
  assign s_axis_notifications_TREADY = notif_rdy & ~rst;
  assign m_axis_read_package_TVALID  = req_vld & ~rst;
  assign s_axis_rx_metadata_TREADY   = meta_rdy & ~rst;
  assign pkt_tx_TVALID               = tx_vld & ~rst;
  assign s_axis_rx_data_TREADY       = rx_rdy & ~rst;

  assign m_axis_read_package_TDATA = {req_len_q, req_sid_q};
  assign pkt_tx_TDATA = {req_len_q, out_sid_q, s_axis_rx_data_TLAST, s_axis_rx_data_TDATA};

  assign stat_pkt_count    = pkt_cnt_q;
  assign stat_drop_count   = drop_cnt_q;
  assign stat_sid_mismatch = mismatch_q;

endmodule

// File: tb/tb_pkt_receiver.sv
// Scoreboard bench for pkt_receiver: a stack/consumer model drives reads, monitors
// compare every read request and output beat against queued expectations.
module tb_pkt_receiver;

  logic         clk = 1'b0;
  logic         rst;
  logic [87:0]  notif_data;
  logic         notif_valid, notif_ready;
  logic [31:0]  rp_data;
  logic         rp_valid, rp_ready;
  logic [15:0]  meta_data;
  logic         meta_valid, meta_ready;
  logic [511:0] rx_data;
  logic [63:0]  rx_keep;
  logic         rx_last, rx_valid, rx_ready;
  logic [544:0] tx_data;
  logic         tx_valid, tx_ready;
  logic [31:0]  pkt_cnt, drop_cnt;
  logic         mism;

  always #5 clk = ~clk;

  pkt_receiver #(.DATA_W(512), .SID_W(16), .LEN_W(16)) dut (
    .clk                         (clk),
    .rst                         (rst),
    .s_axis_notifications_TDATA  (notif_data),
    .s_axis_notifications_TVALID (notif_valid),
    .s_axis_notifications_TREADY (notif_ready),
    .m_axis_read_package_TDATA   (rp_data),
    .m_axis_read_package_TVALID  (rp_valid),
    .m_axis_read_package_TREADY  (rp_ready),
    .s_axis_rx_metadata_TDATA    (meta_data),
    .s_axis_rx_metadata_TVALID   (meta_valid),
    .s_axis_rx_metadata_TREADY   (meta_ready),
    .s_axis_rx_data_TDATA        (rx_data),
    .s_axis_rx_data_TKEEP        (rx_keep),
    .s_axis_rx_data_TLAST        (rx_last),
    .s_axis_rx_data_TVALID       (rx_valid),
    .s_axis_rx_data_TREADY       (rx_ready),
    .pkt_tx_TDATA                (tx_data),
    .pkt_tx_TVALID               (tx_valid),
    .pkt_tx_TREADY               (tx_ready),
    .stat_pkt_count              (pkt_cnt),
    .stat_drop_count             (drop_cnt),
    .stat_sid_mismatch           (mism)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0]  req_q[$];
  logic [544:0] out_q[$];

  int unsigned exp_pkt  = 0;
  int unsigned exp_drop = 0;
  bit          exp_mis  = 1'b0;
  int          pat      = 0;

  task automatic check(input string name, input logic [544:0] act, input logic [544:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  // Monitors: every accepted request or output beat must match the head of its queue.
  always @(negedge clk) begin
    if (!rst && rp_valid && rp_ready) begin
      if (req_q.size() == 0) begin
        n_checks++;
        $display("FAIL read_req_unexpected: got %h expected none", rp_data);
      end else check("read_req", rp_data, req_q.pop_front());
    end
    if (!rst && tx_valid && tx_ready) begin
      if (out_q.size() == 0) begin
        n_checks++;
        $display("FAIL beat_unexpected: got %h expected none", tx_data);
      end else check("out_beat", tx_data, out_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_notif(input logic [15:0] sid, input logic [15:0] len, input bit closed);
    notif_data  = {7'd0, closed, 16'($urandom), 32'($urandom), len, sid};
    notif_valid = 1'b1;
  endtask

  task automatic notif_hs(input logic [15:0] len, input bit closed, input bit immediate);
    bit hs = 1'b0;
    int waited = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (notif_ready) begin hs = 1'b1; break; end
      waited++;
    end
    if (!hs) fail("notif_timeout");
    if (immediate) check("notif_accept_on_idle", waited, 0);
    tick();
    notif_valid = 1'b0;
    if (closed || len == 16'd0) begin
      exp_drop++;
      check("drop_count", drop_cnt, exp_drop);
      check("no_req_after_drop", rp_valid, 0);
    end else begin
      check("req_valid_next_cycle", rp_valid, 1);
    end
  endtask

  task automatic req_phase(input logic [15:0] sid, input logic [15:0] len, input int stall);
    bit hs = 1'b0;
    req_q.push_back({len, sid});
    rp_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_req_valid", rp_valid, 1);
      check("stall_req_data", rp_data, {len, sid});
      check("stall_notif_ready", notif_ready, 0);
      check("stall_meta_ready", meta_ready, 0);
      tick();
    end
    rp_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rp_valid) begin hs = 1'b1; break; end
    end
    if (!hs) fail("req_timeout");
    tick();
    rp_ready = 1'b0;
  endtask

  task automatic meta_phase(input logic [15:0] req_sid, input logic [15:0] msid);
    bit hs = 1'b0;
    meta_data  = msid;
    meta_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (meta_ready) begin hs = 1'b1; break; end
    end
    if (!hs) fail("meta_timeout");
    tick();
    meta_valid = 1'b0;
    if (msid != req_sid) exp_mis = 1'b1;
    check("sid_mismatch", mism, exp_mis);
    pat = 0;
  endtask

  task automatic send_beat(input logic [15:0] len, input logic [15:0] osid, input bit last,
                           input int mode);
    bit hs = 1'b0;
    for (int k = 0; k < 16; k++) rx_data[k*32 +: 32] = $urandom;
    rx_keep  = {$urandom, $urandom};
    rx_last  = last;
    rx_valid = 1'b1;
    out_q.push_back({len, osid, last, rx_data});
    for (int i = 0; i < 100; i++) begin
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (pat % 4 == 0) || (pat % 4 == 3);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      pat++;
      @(negedge clk);
      check("rx_ready_follows", rx_ready, tx_ready);
      check("notif_ready_busy", notif_ready, 0);
      if (tx_valid && tx_ready) begin hs = 1'b1; break; end
      tick();
    end
    if (!hs) fail("beat_timeout");
    tick();
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    if (last) begin
      exp_pkt++;
      check("pkt_count", pkt_cnt, exp_pkt);
      check("idle_after_last", notif_ready, 1);
    end
  endtask

  task automatic do_read(input logic [15:0] sid, input logic [15:0] len, input logic [15:0] msid,
                         input int nbeats, input int stall, input int mode, input bit already,
                         input bit preload, input logic [15:0] psid, input logic [15:0] plen);
    if (!already) set_notif(sid, len, 1'b0);
    notif_hs(len, 1'b0, already);
    req_phase(sid, len, stall);
    meta_phase(sid, msid);
    for (int b = 0; b < nbeats; b++) begin
      if (preload && b == nbeats - 1) set_notif(psid, plen, 1'b0);
      send_beat(len, msid, b == nbeats - 1, mode);
    end
  endtask

  initial begin
    rst = 1'b1;
    notif_data = '0; notif_valid = 1'b0;
    rp_ready = 1'b0;
    meta_data = '0; meta_valid = 1'b0;
    rx_data = '0; rx_keep = '0; rx_last = 1'b0; rx_valid = 1'b0;
    tx_ready = 1'b0;
    repeat (4) tick();

    @(negedge clk);
    check("rst_notif_ready", notif_ready, 0);
    check("rst_req_valid", rp_valid, 0);
    check("rst_meta_ready", meta_ready, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_pkt_count", pkt_cnt, 0);
    check("rst_drop_count", drop_cnt, 0);
    check("rst_mismatch", mism, 0);
    check("rst_req_data", rp_data, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("notif_ready_after_rst", notif_ready, 1);
    tick();

    // Single read
    do_read(16'h0005, 16'd64, 16'h0005, 1, 0, 0, 1'b0, 1'b0, '0, '0);

    // Multi-beat with 1,0,0,1 back-pressure
    do_read(16'h0011, 16'd256, 16'h0011, 4, 0, 1, 1'b0, 1'b0, '0, '0);

    // Discards
    set_notif(16'h0007, 16'd64, 1'b1); notif_hs(16'd64, 1'b1, 1'b0);
    set_notif(16'h0008, 16'd0,  1'b0); notif_hs(16'd0,  1'b0, 1'b0);
    set_notif(16'h0009, 16'd32, 1'b1); notif_hs(16'd32, 1'b1, 1'b0);
    check("drop_count_three", drop_cnt, 3);

    // Back-to-back: second notification waits through DATA
    do_read(16'h0021, 16'd128, 16'h0021, 2, 0, 0, 1'b0, 1'b1, 16'h0022, 16'd64);
    do_read(16'h0022, 16'd64,  16'h0022, 1, 0, 0, 1'b1, 1'b0, '0, '0);

    // Stalled request
    do_read(16'h0031, 16'd64, 16'h0031, 1, 10, 0, 1'b0, 1'b0, '0, '0);

    // Mismatch, then reset during the second beat
    set_notif(16'h0005, 16'd128, 1'b0);
    notif_hs(16'd128, 1'b0, 1'b0);
    req_phase(16'h0005, 16'd128, 0);
    meta_phase(16'h0005, 16'h0009);
    check("mismatch_set", mism, 1);
    send_beat(16'd128, 16'h0009, 1'b0, 0);
    for (int k = 0; k < 16; k++) rx_data[k*32 +: 32] = $urandom;
    rx_last = 1'b0; rx_valid = 1'b1; tx_ready = 1'b1; rst = 1'b1;
    @(negedge clk);
    check("rst_mid_tx_valid", tx_valid, 0);
    tick();
    check("rst_read_tx_valid", tx_valid, 0);
    check("rst_read_req_valid", rp_valid, 0);
    check("rst_read_pkt_count", pkt_cnt, 0);
    check("rst_read_drop_count", drop_cnt, 0);
    check("rst_read_mismatch", mism, 0);
    exp_pkt = 0; exp_drop = 0; exp_mis = 1'b0;
    out_q.delete();
    rst = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
    @(negedge clk);
    check("notif_ready_after_mid_rst", notif_ready, 1);
    tick();

    // Randomized reads with interleaved discards
    for (int n = 0; n < 20; n++) begin
      logic [15:0] sid, msid;
      int nb;
      if ($urandom_range(0, 3) == 0) begin
        bit zl = 1'($urandom_range(0, 1));
        logic [15:0] dl = zl ? 16'd0 : 16'($urandom_range(1, 4096));
        set_notif(16'($urandom), dl, !zl);
        notif_hs(dl, !zl, 1'b0);
      end
      sid  = 16'($urandom);
      msid = ($urandom_range(0, 4) == 0) ? 16'($urandom) : sid;
      nb   = $urandom_range(1, 4);
      do_read(sid, 16'(nb * 64), msid, nb, $urandom_range(0, 3), $urandom_range(0, 2),
              1'b0, 1'b0, '0, '0);
    end

    repeat (3) tick();
    check("req_queue_drained", req_q.size(), 0);
    check("beat_queue_drained", out_q.size(), 0);
    check("final_pkt_count", pkt_cnt, exp_pkt);
    check("final_drop_count", drop_cnt, exp_drop);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pkt_receiver.md
# pkt_receiver

Receive-side counterpart of the top-k kernel's transmit path. Consumes TCP/IP stack notifications and issues read requests. Accepts the per-read session metadata and payload beats from the stack, then presents each beat to the top-k logic as one packed word: metadata, last flag and 512-bit data. Sits between the 100G TCP/IP stack RX interfaces and the packet parser.

## Interface
Parameters:
- `DATA_W`, default 512: payload width in bits; the only supported value is 512.
- `SID_W`, default 16: session ID width.
- `LEN_W`, default 16: notification and read length width, in bytes.

Ports:
- `clk` in 1: single clock; every port is synchronous to it.
- `rst` in 1: synchronous, active-high reset.
- `s_axis_notifications_TDATA` in 88: notification; see field layout below.
  - [15:0] session; [31:16] length; [63:32] IP; [79:64] port; [80] closed.
- `s_axis_notifications_TVALID` in 1 / `s_axis_notifications_TREADY` out 1.
- `m_axis_read_package_TDATA` out 32: read request, {length[15:0], session[15:0]}.
- `m_axis_read_package_TVALID` out 1 / `m_axis_read_package_TREADY` in 1.
- `s_axis_rx_metadata_TDATA` in 16: session of the read being returned.
- `s_axis_rx_metadata_TVALID` in 1 / `s_axis_rx_metadata_TREADY` out 1.
- `s_axis_rx_data_TDATA` in 512, `s_axis_rx_data_TKEEP` in 64, `s_axis_rx_data_TLAST` in 1, `s_axis_rx_data_TVALID` in 1 / `s_axis_rx_data_TREADY` out 1.
- `pkt_tx_TDATA` out 545: output word, fields as listed.
  - [544:529] read length.
  - [528:513] session.
  - [512] last.
  - [511:0] data.
- `pkt_tx_TVALID` out 1 / `pkt_tx_TREADY` in 1.
- `stat_pkt_count` out 32: number of reads completed (beat with last accepted downstream).
- `stat_drop_count` out 32: number of notifications discarded.
- `stat_sid_mismatch` out 1: sticky flag; metadata session differed from the requested session.

## Operation
- Four-state FSM: IDLE, REQ, META, DATA.
- IDLE:
  - `s_axis_notifications_TREADY`=1; all other READY/VALID outputs are 0.
  - When a notification is accepted:
    - closed=1 or length=0 → discard it, increment `stat_drop_count`, stay in IDLE.
    - Otherwise → latch session and length, go to REQ.
- REQ:
  - `m_axis_read_package_TVALID`=1 with the latched {length, session}, held stable until TREADY.
  - Handshake → META.
- META:
  - `s_axis_rx_metadata_TREADY`=1.
  - On accept: latch the metadata session as the output session.
  - If it differs from the requested session, set `stat_sid_mismatch`; it stays set until `rst`.
  - Go to DATA.
- DATA: combinational pass-through, no buffering.
  - `pkt_tx_TVALID` = `s_axis_rx_data_TVALID`.
  - `s_axis_rx_data_TREADY` = `pkt_tx_TREADY`.
  - `pkt_tx_TDATA` = {latched length, latched metadata session, `s_axis_rx_data_TLAST`, `s_axis_rx_data_TDATA`}.
  - TKEEP is ignored; partial beats are forwarded whole.
  - A beat with TLAST accepted (VALID & READY) → increment `stat_pkt_count`, go to IDLE.
- Counters are 32-bit and wrap modulo 2^32 with no saturation.
- Outside DATA: `pkt_tx_TVALID`=0 and `s_axis_rx_data_TREADY`=0. Stray data beats are back-pressured, never dropped.
- Only one read is outstanding at a time. Notifications arriving in REQ, META or DATA wait, because TREADY=0 in those states.

## Timing
- Reset values, held while `rst`=1: state=IDLE, all VALID outputs 0, `s_axis_notifications_TREADY` 0.
  - TREADY rises the first cycle after `rst` deasserts.
- Reset values of data outputs: latched session/length 0, both counters 0, `stat_sid_mismatch` 0.
- `rst` asserted mid-read: FSM returns to IDLE on the next edge.
  - Any partially forwarded read is abandoned; no last beat is generated.
- Minimum overhead per read: 3 cycles (notification accept, request handshake, metadata accept) before the first data beat can pass.
- Data latency: 0 cycles (combinational). Throughput in DATA is 1 beat/cycle when VALID and READY are both held.
- Valid read in IDLE: the notification handshake cycle is followed by `m_axis_read_package_TVALID`=1 on the next cycle.
- Transition after last beat: from the cycle the last beat is accepted, the next edge enters IDLE. A new notification can be accepted in the following cycle.
- Closed or zero-length notifications can be accepted every cycle.
- `stat_drop_count` updates one cycle after the notification handshake. `stat_pkt_count` updates one cycle after the last-beat handshake.

## Test plan
- Single read:
  - Stimulus: notification session=0x0005, length=64, closed=0; stack accepts the request immediately; metadata 0x0005; one data beat with TLAST.
  - Required: read request TDATA=0x00400005.
  - Required: `pkt_tx_TDATA`[544:513]=0x0040_0005, [512]=1, data matches.
  - Required: `stat_pkt_count`=1 and FSM back in IDLE.
- Multi-beat with back-pressure:
  - Stimulus: length=256, 4 beats; `pkt_tx_TREADY` toggles 1,0,0,1 cycle by cycle.
  - Required: `s_axis_rx_data_TREADY` follows `pkt_tx_TREADY` exactly; all 4 beats delivered in order; no beat lost or duplicated.
- Discards:
  - Stimulus: notifications with closed=1, then length=0, then closed=1.
  - Required: no read requests issued; `stat_drop_count`=3.
- Back-to-back reads:
  - Stimulus: second notification already valid while the first read is in DATA.
  - Required: the second notification is held until IDLE, then accepted.
  - Required: its request appears exactly one cycle after acceptance.
  - Required: `stat_pkt_count`=2 at the end.
- Mismatch and reset:
  - Stimulus: metadata 0x0009 for a request on session 0x0005.
  - Required: `stat_sid_mismatch`=1; output session is 0x0009.
  - Stimulus: assert `rst` during the second beat.
  - Required: all VALIDs 0 on the next cycle; counters and flag cleared.
- Stalled request:
  - Stimulus: `m_axis_read_package_TREADY`=0 for 10 cycles.
  - Required: request TVALID and TDATA stay stable throughout.
  - Required: metadata and notification TREADY stay 0 until the handshake.
